fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns the PC register, next-PC select
//  (sequential / branch-jump / eret / exception entry), instruction-memory
//  addressing, fetch address checks and delay-slot tagging. Outputs feed the
//  IF/ID pipeline register directly (InstrF, PCF, PC4F, BDF, ExcCodeF).
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on Reset
//  EXC_ENTRY  32'h0000_4180  handler entry loaded on IntReq
//  IM_BASE    32'h0000_3000  lowest legal fetch address
//  IM_WORDS   4096           IM depth in words; legal range IM_BASE..IM_BASE+4*IM_WORDS-4
// PORTS
//  Clk            in   1   clock, all state updates on posedge
//  Reset          in   1   synchronous, active-high
//  PCEn           in   1   1 = PC may advance; 0 = stall, PC holds
//  IntReq         in   1   exception/interrupt taken by CP0; overrides stall
//  EretD          in   1   eret decoded in D; next PC = EPC (no delay slot)
//  EPC            in   32  return address from CP0
//  BranchTakenD   in   1   branch/jump in D resolved taken
//  BranchTargetD  in   32  target of taken branch/jump in D
//  JumpD          in   1   D holds a branch/jump (taken or not): F is its delay slot
//  IMAddr         out  12  word index into IM = (PCF-IM_BASE)[13:2]
//  IMData         in   32  IM read data, combinational from IMAddr
//  PCF            out  32  address of instruction in F
//  PC4F           out  32  PCF + 4
//  InstrF         out  32  fetched instruction (0 = nop when fetch faults)
//  BDF            out  1   instruction in F is a branch delay slot
//  ExcCodeF       out  5   [6:2] exception code for F; 0 none, 5'd4 AdEL
// BEHAVIOUR
//  - State: single 32-bit PC register; PCF = PC. All other outputs combinational
//    from PC and inputs (zero added latency; IF/ID register supplies the stage).
//  - Reset (sync): PC <= RESET_PC. Outputs after reset: PCF=RESET_PC,
//    PC4F=RESET_PC+4, ExcCodeF=0, InstrF=IMData at index 0, BDF=JumpD.
//  - Next-PC priority each posedge, highest first:
//    1 Reset -> RESET_PC; 2 IntReq -> EXC_ENTRY (ignores PCEn);
//    3 PCEn=0 -> hold; 4 EretD -> EPC; 5 BranchTakenD -> BranchTargetD;
//    6 else PC+4.
//  - Simultaneous IntReq+EretD or IntReq+BranchTakenD: IntReq wins. EretD+
//    BranchTakenD cannot both be valid; EretD wins if asserted together.
//  - PC4F = PC+4 mod 2^32 (0xFFFF_FFFC wraps to 0); no carry out.
//  - Fetch fault: PC[1:0]!=0 OR PC<IM_BASE OR PC>IM_BASE+4*IM_WORDS-4 ->
//    ExcCodeF=5'd4, InstrF=0. Otherwise ExcCodeF=0, InstrF=IMData.
//    IMAddr driven from PC regardless (value ignored on fault).
//  - Faulted PC is still forwarded on PCF/PC4F (becomes EPC/BadVAddr downstream).
//  - BDF = JumpD, independent of PCEn and of fault; flush of F after eret/
//    exception is performed by the IF/ID register, not here.
//  - Reset asserted mid-stall or mid-redirect: Reset wins, no residual state.
// TESTING
//  1 Reset 2 cycles, PCEn=1 -> PCF 0x3000,0x3004,0x3008 on successive cycles; PC4F=PCF+4.
//  2 At PCF=0x3008 BranchTakenD=1,Target=0x3100 -> next PCF=0x3100; PCEn=0 for 3 cycles -> PCF holds 0x3100.
//  3 PCEn=0 and IntReq=1 at PCF=0x3100 -> next PCF=0x4180; EretD+IntReq same edge -> 0x4180.
//  4 EretD=1,EPC=0x3002 -> PCF=0x3002, ExcCodeF=4, InstrF=0; EPC=0x7000 -> ExcCodeF=4; EPC=0x6FFC -> ExcCodeF=0, IMAddr=0xFFF.
//  5 JumpD=1 with PCEn=0 -> BDF=1 while held; JumpD=0 -> BDF=0.
//  6 Reset asserted same edge as IntReq/BranchTakenD -> PCF=0x3000.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IM addressing, fetch address
// checks and delay-slot tagging. Outputs feed the IF/ID register directly.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int unsigned IM_WORDS  = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCEn,
  input  logic        IntReq,
  input  logic        EretD,
  input  logic [31:0] EPC,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic        JumpD,
  output logic [11:0] IMAddr,
  input  logic [31:0] IMData,
  output logic [31:0] PCF,
  output logic [31:0] PC4F,
  output logic [31:0] InstrF,
  output logic        BDF,
  output logic [4:0]  ExcCodeF
);

  // Byte offset of the last legal word relative to IM_BASE.
  localparam logic [31:0] IM_SPAN_LAST = 32'(IM_WORDS * 4) - 32'd4;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_EXC,
    SEL_HOLD,
    SEL_ERET,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_off;
  logic        fetch_fault;
  pc_sel_e     pc_sel;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC source, highest priority first; IntReq overrides a stall.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (Reset)             pc_sel = SEL_RESET;
    else if (IntReq)       pc_sel = SEL_EXC;
    else if (!PCEn)        pc_sel = SEL_HOLD;
    else if (EretD)        pc_sel = SEL_ERET;
    else if (BranchTakenD) pc_sel = SEL_BRANCH;
  end

  // Next-PC value for the selected source.
  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      SEL_RESET:  pc_d = RESET_PC;
      SEL_EXC:    pc_d = EXC_ENTRY;
      SEL_HOLD:   pc_d = pc_q;
      SEL_ERET:   pc_d = EPC;
      SEL_BRANCH: pc_d = BranchTargetD;
      default:    pc_d = pc_plus4;
    endcase
  end

  // PC register; reset is folded into the select above (synchronous).
  always_ff @(posedge Clk) begin
    pc_q <= pc_d;
  end

  // Fetch address check. Offsets below IM_BASE wrap to large values, so a
  // single unsigned compare on the offset covers both range bounds.
  always_comb begin
    pc_off      = pc_q - IM_BASE;
    fetch_fault = (pc_q[1:0] != 2'b00) || (pc_off > IM_SPAN_LAST);
  end

  assign IMAddr   = pc_off[13:2];
  assign PCF      = pc_q;
  assign PC4F     = pc_plus4;
  assign InstrF   = fetch_fault ? '0 : IMData;
  assign ExcCodeF = fetch_fault ? EXC_ADEL : 5'd0;
  assign BDF      = JumpD;

endmodule
